// File: rtl/pci_burst_initiator_pkg.sv
// Shared types and constants for the PCI burst initiator.
// Bus-side signals are active-low, so the assert/deassert levels are named here.
package pci_init_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    ADDR,
    DATA,
    TURN
  } state_t;

  localparam logic PCI_ASSERT   = 1'b0;
  localparam logic PCI_DEASSERT = 1'b1;

endpackage

// File: rtl/pci_burst_initiator_if.sv
// Handshake and bus signals between the initiator and the arbiter / PCI bus.
// The master modport is the initiator's view; slave is the environment's view.
interface pci_burst_initiator_if #(
  parameter int LEN_W = 5
);

  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic             GNT;
  logic             TRDY;
  logic             GLOBAL_FRAME;
  logic             GLOBAL_IRDY;
  logic             REQ;
  logic             FRAME;
  logic             IRDY;
  logic             I_AM_OWNER;
  logic             data_ack;
  logic             done;
  logic [LEN_W-1:0] xfer_count;

  modport master (
    input  start, burst_len, GNT, TRDY, GLOBAL_FRAME, GLOBAL_IRDY,
    output REQ, FRAME, IRDY, I_AM_OWNER, data_ack, done, xfer_count
  );

  modport slave (
    output start, burst_len, GNT, TRDY, GLOBAL_FRAME, GLOBAL_IRDY,
    input  REQ, FRAME, IRDY, I_AM_OWNER, data_ack, done, xfer_count
  );

endinterface

// File: rtl/pci_burst_initiator_latency_timer.sv
// Latency-timer down-counter: loaded at the address phase, counts down during data
// phases and saturates at zero, where it reports expiry.
module pci_latency_timer #(
  parameter int LAT_TIMER = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LAT_TIMER + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CW'(LAT_TIMER);
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/pci_burst_initiator.sv
// PCI bus-master burst initiator: request, one address phase, 1..MAX_BURST data phases, release.
// Optional macro PCI_LAT_TIMER_EN adds latency-timer truncation when the grant is withdrawn.
module pci_burst_initiator
  import pci_init_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST + 1),
  parameter int LAT_TIMER = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  pci_burst_initiator_if.master bus
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             req_q, req_d;
  logic             frame_q, frame_d;
  logic             irdy_q, irdy_d;
  logic             owner_q, owner_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] len_clamped;
  logic             bus_idle;
  logic             phase_done;
  logic             truncate;

  assign bus_idle   = bus.GLOBAL_FRAME & bus.GLOBAL_IRDY;
  assign phase_done = (irdy_q == PCI_ASSERT) && (bus.TRDY == PCI_ASSERT);

  always_comb begin
    if (bus.burst_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (bus.burst_len > LEN_W'(MAX_BURST)) begin
      len_clamped = LEN_W'(MAX_BURST);
    end else begin
      len_clamped = bus.burst_len;
    end
  end

`ifdef PCI_LAT_TIMER_EN
  logic lat_expired;

  pci_latency_timer #(
    .LAT_TIMER(LAT_TIMER)
  ) u_lat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == ADDR),
    .en     (state_q == DATA),
    .expired(lat_expired)
  );

  assign truncate = lat_expired && (bus.GNT == PCI_DEASSERT);
`else
  assign truncate = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      req_q       <= PCI_DEASSERT;
      frame_q     <= PCI_DEASSERT;
      irdy_q      <= PCI_DEASSERT;
      owner_q     <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      req_q       <= req_d;
      frame_q     <= frame_d;
      irdy_q      <= irdy_d;
      owner_q     <= owner_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
    end
  end

  // A deasserted FRAME# during DATA marks the pending phase as the last one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = REQUEST;
      REQUEST: if ((bus.GNT == PCI_ASSERT) && bus_idle) state_d = ADDR;
      ADDR:    state_d = DATA;
      DATA:    if (phase_done && (frame_q == PCI_DEASSERT)) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    remaining_d = remaining_q;
    count_d     = count_q;
    req_d       = req_q;
    frame_d     = frame_q;
    irdy_d      = irdy_q;
    owner_d     = owner_q;
    ack_d       = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          remaining_d = len_clamped;
          count_d     = '0;
          req_d       = PCI_ASSERT;
        end
      end
      REQUEST: begin
        if ((bus.GNT == PCI_ASSERT) && bus_idle) begin
          frame_d = PCI_ASSERT;
          req_d   = PCI_DEASSERT;
          owner_d = 1'b1;
        end else begin
          req_d = PCI_ASSERT;
        end
      end
      ADDR: begin
        irdy_d  = PCI_ASSERT;
        frame_d = (remaining_q == LEN_W'(1)) ? PCI_DEASSERT : PCI_ASSERT;
      end
      DATA: begin
        if (phase_done) begin
          ack_d       = 1'b1;
          count_d     = count_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (frame_q == PCI_DEASSERT) begin
            irdy_d  = PCI_DEASSERT;
            owner_d = 1'b0;
            done_d  = 1'b1;
          end else if (remaining_q == LEN_W'(2)) begin
            frame_d = PCI_DEASSERT;
          end
        end
        if ((frame_q == PCI_ASSERT) && truncate && (remaining_q >= LEN_W'(2))) begin
          frame_d = PCI_DEASSERT;
        end
      end
      TURN: begin
      end
      default: begin
      end
    endcase
  end

  assign bus.REQ        = req_q;
  assign bus.FRAME      = frame_q;
  assign bus.IRDY       = irdy_q;
  assign bus.I_AM_OWNER = owner_q;
  assign bus.data_ack   = ack_q;
  assign bus.done       = done_q;
  assign bus.xfer_count = count_q;

endmodule

// File: tb/tb_pci_burst_initiator.sv
// Directed self-checking bench for pci_burst_initiator; outputs sampled on the falling edge.
// Status vector order: {REQ, FRAME, IRDY, I_AM_OWNER, data_ack, done}.
module tb_pci_burst_initiator;

  localparam int MAX_BURST = 16;
  localparam int LEN_W     = $clog2(MAX_BURST + 1);
  localparam int LAT_TIMER = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic other_frame = 1'b1;
  logic other_irdy = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pci_burst_initiator_if #(.LEN_W(LEN_W)) bus_if ();

  // Wired-AND bus: other masters plus this initiator's own drivers.
  assign bus_if.GLOBAL_FRAME = bus_if.FRAME & other_frame;
  assign bus_if.GLOBAL_IRDY  = bus_if.IRDY & other_irdy;

  pci_burst_initiator #(
    .MAX_BURST(MAX_BURST),
    .LEN_W    (LEN_W),
    .LAT_TIMER(LAT_TIMER)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  logic [5:0] outs;
  assign outs = {bus_if.REQ, bus_if.FRAME, bus_if.IRDY, bus_if.I_AM_OWNER, bus_if.data_ack, bus_if.done};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_done(input int budget, output int acks, output bit seen);
    acks = 0;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus_if.data_ack === 1'b1) acks++;
      if (bus_if.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus_if.start     = 1'b0;
    bus_if.burst_len = '0;
    bus_if.GNT       = 1'b1;
    bus_if.TRDY      = 1'b1;
    rst_n            = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL reset_outs: got %b expected %b", outs, 6'b111000);
    end
    checks++;
    if (bus_if.xfer_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_xfer: got %0d expected 0", bus_if.xfer_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %b expected %b", outs, 6'b111000);
    end
  endtask

  task automatic test_single();
    logic [5:0] exp_outs [5];
    exp_outs = '{6'b011000, 6'b101100, 6'b110100, 6'b111011, 6'b111000};
    bus_if.GNT       = 1'b0;
    bus_if.TRDY      = 1'b0;
    bus_if.burst_len = LEN_W'(1);
    bus_if.start     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus_if.start = 1'b0;
      checks++;
      if (outs !== exp_outs[i]) begin
        errors++;
        $display("[TB] FAIL single_cyc%0d: got %b expected %b", i + 1, outs, exp_outs[i]);
      end
    end
    checks++;
    if (bus_if.xfer_count !== LEN_W'(1)) begin
      errors++;
      $display("[TB] FAIL single_xfer: got %0d expected 1", bus_if.xfer_count);
    end
  endtask

  task automatic test_wait_states();
    logic [5:0] exp_outs [10];
    logic       trdy [10];
    exp_outs = '{6'b011000, 6'b101100, 6'b100100, 6'b100110, 6'b100100,
                 6'b100100, 6'b100110, 6'b110110, 6'b111011, 6'b111000};
    trdy     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus_if.GNT       = 1'b0;
    bus_if.burst_len = LEN_W'(4);
    bus_if.start     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_if.TRDY = trdy[i];
      tick();
      bus_if.start = 1'b0;
      checks++;
      if (outs !== exp_outs[i]) begin
        errors++;
        $display("[TB] FAIL wait_cyc%0d: got %b expected %b", i + 1, outs, exp_outs[i]);
      end
    end
    checks++;
    if (bus_if.xfer_count !== LEN_W'(4)) begin
      errors++;
      $display("[TB] FAIL wait_xfer: got %0d expected 4", bus_if.xfer_count);
    end
  endtask

  task automatic test_bus_busy();
    logic [5:0] exp_outs [8];
    logic       busy [8];
    exp_outs = '{6'b011000, 6'b011000, 6'b011000, 6'b011000,
                 6'b101100, 6'b110100, 6'b111011, 6'b111000};
    busy     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus_if.GNT       = 1'b0;
    bus_if.TRDY      = 1'b0;
    bus_if.burst_len = LEN_W'(1);
    bus_if.start     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      other_frame = ~busy[i];
      tick();
      bus_if.start = 1'b0;
      checks++;
      if (outs !== exp_outs[i]) begin
        errors++;
        $display("[TB] FAIL busy_cyc%0d: got %b expected %b", i + 1, outs, exp_outs[i]);
      end
    end
    other_frame = 1'b1;
  endtask

  task automatic test_reset_mid();
    bus_if.GNT       = 1'b0;
    bus_if.TRDY      = 1'b0;
    bus_if.burst_len = LEN_W'(8);
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (3) tick();
    checks++;
    if (outs !== 6'b100110) begin
      errors++;
      $display("[TB] FAIL rstmid_phase1: got %b expected %b", outs, 6'b100110);
    end
    bus_if.TRDY = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL rstmid_async: got %b expected %b", outs, 6'b111000);
    end
    checks++;
    if (bus_if.xfer_count !== '0) begin
      errors++;
      $display("[TB] FAIL rstmid_xfer: got %0d expected 0", bus_if.xfer_count);
    end
    @(negedge clk);
    tick();
    rst_n       = 1'b1;
    bus_if.TRDY = 1'b0;
    tick();
    checks++;
    if (outs !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL rstmid_after: got %b expected %b", outs, 6'b111000);
    end
  endtask

  task automatic test_lat_timer();
    int acks;
    bit seen;
    bus_if.GNT       = 1'b0;
    bus_if.TRDY      = 1'b0;
    bus_if.burst_len = LEN_W'(16);
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    bus_if.GNT = 1'b1;
    run_until_done(60, acks, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL lat_done: got no done expected done pulse");
    end
`ifdef PCI_LAT_TIMER_EN
    checks++;
    if (!(bus_if.xfer_count < LEN_W'(16)) || bus_if.xfer_count == '0) begin
      errors++;
      $display("[TB] FAIL lat_truncated: got %0d expected 1..15", bus_if.xfer_count);
    end
    checks++;
    if (int'(bus_if.xfer_count) !== acks) begin
      errors++;
      $display("[TB] FAIL lat_acks: got %0d expected %0d", acks, bus_if.xfer_count);
    end
`else
    checks++;
    if (bus_if.xfer_count !== LEN_W'(16)) begin
      errors++;
      $display("[TB] FAIL lat_full: got %0d expected 16", bus_if.xfer_count);
    end
    checks++;
    if (acks !== 16) begin
      errors++;
      $display("[TB] FAIL lat_acks: got %0d expected 16", acks);
    end
`endif
    tick();
  endtask

  task automatic test_ignore_start();
    logic [5:0] exp_outs [6];
    logic       strt [6];
    int         acks;
    bit         seen;
    exp_outs = '{6'b011000, 6'b101100, 6'b110100, 6'b111011, 6'b111000, 6'b111000};
    strt     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bus_if.GNT       = 1'b0;
    bus_if.TRDY      = 1'b0;
    bus_if.burst_len = LEN_W'(0);
    for (int i = 0; i < 6; i++) begin
      bus_if.start = strt[i];
      tick();
      checks++;
      if (outs !== exp_outs[i]) begin
        errors++;
        $display("[TB] FAIL ignore_cyc%0d: got %b expected %b", i + 1, outs, exp_outs[i]);
      end
    end
    bus_if.start = 1'b0;
    checks++;
    if (bus_if.xfer_count !== LEN_W'(1)) begin
      errors++;
      $display("[TB] FAIL len0_xfer: got %0d expected 1", bus_if.xfer_count);
    end
    bus_if.burst_len = LEN_W'(MAX_BURST + 5);
    bus_if.start     = 1'b1;
    tick();
    bus_if.start = 1'b0;
    run_until_done(60, acks, seen);
    checks++;
    if (!seen || acks !== MAX_BURST) begin
      errors++;
      $display("[TB] FAIL clamp_acks: got %0d (done=%0d) expected %0d", acks, seen, MAX_BURST);
    end
    checks++;
    if (bus_if.xfer_count !== LEN_W'(MAX_BURST)) begin
      errors++;
      $display("[TB] FAIL clamp_xfer: got %0d expected %0d", bus_if.xfer_count, MAX_BURST);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wait_states();
    test_bus_busy();
    test_reset_mid();
    test_lat_timer();
    test_ignore_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
